// File: rtl/iob_axistream_in_pkg.sv
// Shared definitions for the AXI-Stream receiver.
// Holds the CPU register map, the packed word width, and helpers that derive
// the number of beats per 32-bit word and the width of one FIFO entry
// ({last, mask[N-1:0], word[31:0]}) from the stream beat width.
package iob_axistream_in_pkg;

  // CPU register addresses
  typedef enum logic [1:0] {
    REG_OUT   = 2'd0,
    REG_EMPTY = 2'd1,
    REG_LAST  = 2'd2,
    REG_LEVEL = 2'd3
  } reg_addr_e;

  localparam int WORD_W = 32;

  // Beats packed into one word (N)
  function automatic int beats_per_word(input int tdata_w);
    return WORD_W / tdata_w;
  endfunction

  // FIFO entry width: last flag + mask + word
  function automatic int entry_width(input int tdata_w);
    return WORD_W + 1 + beats_per_word(tdata_w);
  endfunction

endpackage

// File: rtl/iob_axistream_in_pack.sv
// Beat packer for the AXI-Stream receiver.
// Collects TDATA_W-bit beats little-endian into a 32-bit word with a mask of
// filled slots. A word closes on the last slot or on tlast. If the consumer
// cannot take a closed word, it is parked in a pending register and the
// stream is stalled until it drains, so no beat is ever lost.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   tdata/tvalid/tready/tlast  AXI-Stream slave side
//   word_valid/word_data/word_ready  closed-word handshake towards the FIFO
module iob_axistream_in_pack
  import iob_axistream_in_pkg::*;
#(
  parameter  int TDATA_W = 8,
  localparam int N       = beats_per_word(TDATA_W),
  localparam int ENTRY_W = entry_width(TDATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TDATA_W-1:0] tdata,
  input  logic               tvalid,
  output logic               tready,
  input  logic               tlast,
  output logic               word_valid,
  output logic [ENTRY_W-1:0] word_data,
  input  logic               word_ready
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  logic [CNT_W-1:0]   cnt;
  logic [31:0]        word_reg;
  logic [31:0]        word_next;
  logic [N-1:0]       mask_reg;
  logic [N-1:0]       mask_next;
  logic               pend_valid;
  logic [ENTRY_W-1:0] pend_data;
  logic [ENTRY_W-1:0] entry;
  logic               accept;
  logic               close;
  logic [5:0]         shamt;

  // Held low during reset so no beat is taken while state is being cleared
  assign tready = ~pend_valid & ~rst;
  assign accept = tvalid & tready;

  always_comb begin
    shamt     = 6'(32'(cnt) * TDATA_W);
    word_next = word_reg | (32'(tdata) << shamt);
    mask_next = mask_reg | (N'(1) << cnt);
    close     = accept & ((cnt == CNT_W'(N - 1)) | tlast);
    entry     = {tlast, mask_next, word_next};
  end

  // The pending word always has priority; no new word can close meanwhile
  assign word_valid = pend_valid | close;
  assign word_data  = pend_valid ? pend_data : entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      word_reg   <= '0;
      mask_reg   <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else begin
      if (accept) begin
        if (close) begin
          cnt      <= '0;
          word_reg <= '0;
          mask_reg <= '0;
        end else begin
          cnt      <= cnt + CNT_W'(1);
          word_reg <= word_next;
          mask_reg <= mask_next;
        end
      end
      if (pend_valid && word_ready) begin
        pend_valid <= 1'b0;
      end else if (close && !word_ready) begin
        pend_valid <= 1'b1;
        pend_data  <= entry;
      end
    end
  end

endmodule

// File: rtl/iob_axistream_in.sv
// AXI-Stream receiver with a CPU-side IOb register interface.
// Beats are packed into 32-bit words, buffered in a synchronous FIFO of
// {last, mask, word} entries, and popped by firmware reading OUT.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   valid/address/wdata/wstrb     CPU request (writes acknowledged, ignored)
//   rdata/ready                   registered CPU response, one cycle later
//   tdata/tvalid/tready/tlast     AXI-Stream slave
//   interrupt                     only with IOB_AXISTREAM_IN_INTERRUPT_EN:
//                                 high while a stored word carries last=1
module iob_axistream_in
  import iob_axistream_in_pkg::*;
#(
  parameter int TDATA_W         = 8,
  parameter int FIFO_DEPTH_LOG2 = 10,
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [ADDR_W-1:0]  address,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [3:0]         wstrb,
  output logic [DATA_W-1:0]  rdata,
  output logic               ready,
  input  logic [TDATA_W-1:0] tdata,
  input  logic               tvalid,
  output logic               tready,
  input  logic               tlast
`ifdef IOB_AXISTREAM_IN_INTERRUPT_EN
  ,
  output logic               interrupt
`endif
);

  localparam int N       = beats_per_word(TDATA_W);
  localparam int ENTRY_W = entry_width(TDATA_W);
  localparam int DEPTH   = 2 ** FIFO_DEPTH_LOG2;
  localparam int LVL_W   = FIFO_DEPTH_LOG2 + 1;

  logic                       word_valid;
  logic                       word_ready;
  logic [ENTRY_W-1:0]         word_data;
  logic [ENTRY_W-1:0]         mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wptr;
  logic [FIFO_DEPTH_LOG2-1:0] rptr;
  logic [LVL_W-1:0]           level;
  logic                       empty;
  logic                       full;
  logic                       rd_req;
  logic                       push;
  logic                       pop;
  logic                       head_last;
  logic [N-1:0]               head_mask;
  logic [31:0]                head_word;
  logic                       unused_wdata;

  assign unused_wdata = ^wdata;

  iob_axistream_in_pack #(.TDATA_W(TDATA_W)) pack (
    .clk        (clk),
    .rst        (rst),
    .tdata      (tdata),
    .tvalid     (tvalid),
    .tready     (tready),
    .tlast      (tlast),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready)
  );

  assign empty  = (level == '0);
  assign full   = (level == LVL_W'(DEPTH));
  assign rd_req = valid & ~|wstrb;
  assign pop    = rd_req & (reg_addr_e'(address[1:0]) == REG_OUT) & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO can still take a push
  assign word_ready = ~full | pop;
  assign push       = word_valid & word_ready;

  assign {head_last, head_mask, head_word} = mem[rptr];

  // FIFO storage, kept reset-free so it maps onto a dual-port RAM
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= word_data;
    end
  end

  // FIFO pointers and fill level; pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + FIFO_DEPTH_LOG2'(1);
      if (pop)  rptr <= rptr + FIFO_DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // CPU register read path; rdata keeps its value across writes
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= valid;
      if (rd_req) begin
        case (reg_addr_e'(address[1:0]))
          REG_OUT:   rdata <= empty ? '0 : DATA_W'(head_word);
          REG_EMPTY: rdata <= DATA_W'(empty);
          REG_LAST:  rdata <= empty ? '0 : DATA_W'({head_mask, head_last});
          REG_LEVEL: rdata <= DATA_W'(level);
          default:   rdata <= '0;
        endcase
      end
    end
  end

`ifdef IOB_AXISTREAM_IN_INTERRUPT_EN
  logic [LVL_W-1:0] last_cnt;
  logic [LVL_W-1:0] last_cnt_next;
  logic             push_last;
  logic             pop_last;

  always_comb begin
    push_last     = push & word_data[ENTRY_W-1];
    pop_last      = pop & head_last;
    last_cnt_next = last_cnt;
    if (push_last && !pop_last)      last_cnt_next = last_cnt + LVL_W'(1);
    else if (pop_last && !push_last) last_cnt_next = last_cnt - LVL_W'(1);
  end

  // Interrupt follows the updated count so it drops right after the pop
  always_ff @(posedge clk) begin
    if (rst) begin
      last_cnt  <= '0;
      interrupt <= 1'b0;
    end else begin
      last_cnt  <= last_cnt_next;
      interrupt <= |last_cnt_next;
    end
  end
`else
  // Without the interrupt, firmware polls EMPTY and LAST
`endif

endmodule

// File: tb/tb_iob_axistream_in.sv
// Self-checking bench for iob_axistream_in (TDATA_W=8, 4-entry FIFO).
module tb_iob_axistream_in;

  localparam int TDATA_W         = 8;
  localparam int FIFO_DEPTH_LOG2 = 2;
  localparam int DATA_W          = 32;
  localparam int ADDR_W          = 2;

  localparam logic [1:0] A_OUT   = 2'd0;
  localparam logic [1:0] A_EMPTY = 2'd1;
  localparam logic [1:0] A_LAST  = 2'd2;
  localparam logic [1:0] A_LEVEL = 2'd3;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic [7:0]        tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
`ifdef IOB_AXISTREAM_IN_INTERRUPT_EN
  logic              interrupt;
`endif

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] exp_out;
    logic [31:0] exp_last;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    int              nb;
    logic [3:0][7:0] beats;
    logic            last;
    logic [31:0]     exp_out;
    logic [31:0]     exp_last;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  iob_axistream_in #(
    .TDATA_W(TDATA_W), .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .tdata(tdata),
    .tvalid(tvalid), .tready(tready), .tlast(tlast)
`ifdef IOB_AXISTREAM_IN_INTERRUPT_EN
    , .interrupt(interrupt)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // One CPU read; returns rdata sampled in the cycle ready should be high
  task automatic cpuRead(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    valid   = 1'b1;
    address = addr;
    wstrb   = 4'h0;
    @(negedge clk);
    valid = 1'b0;
    checkOutput("ready", {31'b0, ready}, 32'h1);
    data = rdata;
  endtask

  // Drive one beat and wait (bounded) until it is accepted
  task automatic applyStimulus(input logic [7:0] data, input logic last);
    int waited = 0;
    @(negedge clk);
    tdata  = data;
    tlast  = last;
    tvalid = 1'b1;
    while (tready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (tready !== 1'b1) begin
      checks++;
      $display("[TB] FAIL beat_timeout: tready=%b, expected 1", tready);
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic sendFrame(input int nb, input logic [3:0][7:0] b, input logic last);
    for (int i = 0; i < nb; i++) applyStimulus(b[i], last && (i == nb - 1));
  endtask

  function automatic logic [31:0] packWord(input int nb, input logic [3:0][7:0] b);
    logic [31:0] w = '0;
    for (int i = 0; i < nb; i++) w |= 32'(b[i]) << (8 * i);
    return w;
  endfunction

  function automatic logic [31:0] packLast(input int nb, input logic last);
    return ((32'h1 << nb) - 32'h1) << 1 | 32'(last);
  endfunction

  task automatic readOutChecked(input string name);
    logic [31:0] d;
    sb_t e;
    cpuRead(A_OUT, d);
    if (sb.size() == 0) begin
      checks++;
      $display("[TB] FAIL %s: got 0x%08h, expected no word queued", name, d);
    end else begin
      e = sb.pop_front();
      checkOutput(name, d, e.exp_out);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [3:0][7:0] b;

    vecs[0] = '{4, 32'h44332211, 1'b1, 32'h44332211, 32'h0000001F};
    vecs[1] = '{2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 32'h00000007};
    vecs[2] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 32'h00000003};
    vecs[3] = '{4, 32'h04030201, 1'b0, 32'h04030201, 32'h0000001E};
    vecs[4] = '{3, 32'h00BEADDE, 1'b1, 32'h00BEADDE, 32'h0000000F};

    rst = 1'b1; valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
    tdata = '0; tvalid = 1'b0; tlast = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_tready", {31'b0, tready}, 32'h0);
    checkOutput("reset_ready", {31'b0, ready}, 32'h0);
    checkOutput("reset_rdata", rdata, 32'h0);
`ifdef IOB_AXISTREAM_IN_INTERRUPT_EN
    checkOutput("reset_interrupt", {31'b0, interrupt}, 32'h0);
`endif
    rst = 1'b0;
    @(negedge clk);
    checkOutput("tready_after_reset", {31'b0, tready}, 32'h1);

    // Empty FIFO reads
    cpuRead(A_OUT, d);   checkOutput("out_empty", d, 32'h0);
    cpuRead(A_LEVEL, d); checkOutput("level_empty", d, 32'h0);
    cpuRead(A_LAST, d);  checkOutput("last_empty", d, 32'h0);
    cpuRead(A_EMPTY, d); checkOutput("empty_flag", d, 32'h1);

    // Table-driven single frames
    for (int v = 0; v < 5; v++) begin
      sendFrame(vecs[v].nb, vecs[v].beats, vecs[v].last);
      sb.push_back('{vecs[v].exp_out, vecs[v].exp_last});
      cpuRead(A_LEVEL, d); checkOutput("vec_level", d, 32'h1);
      cpuRead(A_EMPTY, d); checkOutput("vec_not_empty", d, 32'h0);
      cpuRead(A_LAST, d);  checkOutput("vec_last", d, sb[0].exp_last);
      readOutChecked("vec_out");
      cpuRead(A_EMPTY, d); checkOutput("vec_empty_after", d, 32'h1);
    end

    // Fill the FIFO, then a fifth word must stall in the pending register
    for (int w = 0; w < 5; w++) begin
      for (int j = 0; j < 4; j++) b[j] = 8'(16 * (w + 1) + j + 1);
      sendFrame(4, b, 1'b0);
      sb.push_back('{packWord(4, b), packLast(4, 1'b0)});
    end
    checkOutput("full_tready", {31'b0, tready}, 32'h0);
    cpuRead(A_LEVEL, d); checkOutput("full_level", d, 32'h4);
    checkOutput("still_stalled", {31'b0, tready}, 32'h0);
    readOutChecked("fill_out0");
    checkOutput("tready_after_pop", {31'b0, tready}, 32'h1);
    cpuRead(A_LEVEL, d); checkOutput("level_after_pop_push", d, 32'h4);
    for (int w = 1; w < 5; w++) readOutChecked("fill_out");
    cpuRead(A_EMPTY, d); checkOutput("fill_empty", d, 32'h1);

    // Reset in the middle of a frame discards the partial word
    applyStimulus(8'h77, 1'b0);
    applyStimulus(8'h88, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_tready", {31'b0, tready}, 32'h0);
    checkOutput("midreset_rdata", rdata, 32'h0);
    rst = 1'b0;
    cpuRead(A_EMPTY, d); checkOutput("midreset_empty", d, 32'h1);
    b = 32'h40302010;
    sendFrame(4, b, 1'b1);
    sb.push_back('{32'h40302010, 32'h0000001F});
    cpuRead(A_LAST, d); checkOutput("midreset_last", d, 32'h0000001F);
    readOutChecked("midreset_out");

`ifdef IOB_AXISTREAM_IN_INTERRUPT_EN
    b = 32'h0000BBAA;
    sendFrame(2, b, 1'b1);
    sb.push_back('{32'h0000BBAA, 32'h00000007});
    checkOutput("irq_set", {31'b0, interrupt}, 32'h1);
    readOutChecked("irq_out");
    checkOutput("irq_clear", {31'b0, interrupt}, 32'h0);
`endif

    if (sb.size() != 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_drain: got %0d words left, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
